// File: rtl/scale_div_arb.sv
// scale_div_arb
//   Shares one external divider among four screen read channels. Each renew
//   request computes X and Y scale steps (unsigned, 8 fractional bits) with
//   two serial divisions and commits both atomically to that channel's steps.
//
// Ports
//   rd_clk, rst_n        clock, synchronous active-low reset (shared with divider)
//   renew[3:0]           per-channel recompute request pulse
//   x_rd_size, y_rd_size 4x13 packed output sizes, channel i at [13i+12:13i]
//   div_start            one-cycle divider start
//   div_num, div_den     divider operands, stable until the matching div_done
//   div_done, div_quot   divider result strobe and quotient
//   x_add, y_add         4x20 packed step registers, channel i at [20i+19:20i]
//   upd[3:0]             one-cycle pulse when a channel's steps commit
//   busy                 high whenever the scheduler is not idle
//   err[3:0]             sticky per-channel divider timeout flags
//
// Build option
//   DIV_TIMEOUT_EN       enables the divider watchdog (TIMEOUT cycles per wait);
//                        without it waits are unbounded and err is tied low.

module scale_div_arb #(
  parameter int unsigned X_SIZE  = 960,
  parameter int unsigned Y_SIZE  = 1080,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        rd_clk,
  input  logic        rst_n,
  input  logic [3:0]  renew,
  input  logic [51:0] x_rd_size,
  input  logic [51:0] y_rd_size,
  output logic        div_start,
  output logic [19:0] div_num,
  output logic [19:0] div_den,
  input  logic        div_done,
  input  logic [19:0] div_quot,
  output logic [79:0] x_add,
  output logic [79:0] y_add,
  output logic [3:0]  upd,
  output logic        busy,
  output logic [3:0]  err
);

  typedef enum logic [2:0] {IDLE, X_START, X_WAIT, Y_START, Y_WAIT, COMMIT} state_t;

  localparam logic [19:0] X_NUM = 20'(X_SIZE * 256);
  localparam logic [19:0] Y_NUM = 20'(Y_SIZE * 256);
  localparam logic [19:0] UNITY = 20'd256;

  state_t      state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic [1:0]  rr_q, rr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [12:0] xs_q, xs_d, ys_q, ys_d;
  logic [19:0] num_q, num_d, den_q, den_d;
  logic [19:0] xtmp_q, xtmp_d, ytmp_q, ytmp_d;
  logic [79:0] xadd_q, xadd_d, yadd_q, yadd_d;
  logic [3:0]  upd_q, upd_d;

  logic        gnt_found;
  logic [1:0]  gnt_idx, cand;
  logic [12:0] sel_xs, sel_ys;
  logic        wd_expired;

  // Round-robin search: first pending bit at or after rr_q, wrapping 3->0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_q;
    cand      = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = rr_q + 2'(k);
      if (!gnt_found && pending_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    sel_xs = x_rd_size[13*gnt_idx +: 13];
    sel_ys = y_rd_size[13*gnt_idx +: 13];
  end

`ifdef DIV_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic [3:0]    err_q;

  always_ff @(posedge rd_clk) begin
    if (!rst_n)                                      cnt_q <= '0;
    else if (state_q == X_WAIT || state_q == Y_WAIT) cnt_q <= cnt_q + 1'b1;
    else                                             cnt_q <= '0;
  end

  assign wd_expired = (state_q == X_WAIT || state_q == Y_WAIT) && !div_done &&
                      (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge rd_clk) begin
    if (!rst_n)          err_q <= '0;
    else if (wd_expired) err_q[gnt_q] <= 1'b1;
  end

  assign err = err_q;
`else
  assign wd_expired = 1'b0;
  assign err        = '0;
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    xs_d      = xs_q;
    ys_d      = ys_q;
    num_d     = num_q;
    den_d     = den_q;
    xtmp_d    = xtmp_q;
    ytmp_d    = ytmp_q;
    xadd_d    = xadd_q;
    yadd_d    = yadd_q;
    upd_d     = '0;

    // Zero sizes skip their division; the next START (or COMMIT) is chosen
    // at the point the previous phase ends, loading operands on the way in.
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          pending_d[gnt_idx] = 1'b0;
          gnt_d = gnt_idx;
          xs_d  = sel_xs;
          ys_d  = sel_ys;
          if (sel_xs != '0) begin
            state_d = X_START;
            num_d   = X_NUM;
            den_d   = {7'd0, sel_xs};
          end else begin
            xtmp_d = UNITY;
            if (sel_ys != '0) begin
              state_d = Y_START;
              num_d   = Y_NUM;
              den_d   = {7'd0, sel_ys};
            end else begin
              ytmp_d  = UNITY;
              state_d = COMMIT;
            end
          end
        end
      end
      X_START: state_d = X_WAIT;
      X_WAIT: begin
        if (div_done) begin
          xtmp_d = div_quot;
          if (ys_q != '0) begin
            state_d = Y_START;
            num_d   = Y_NUM;
            den_d   = {7'd0, ys_q};
          end else begin
            ytmp_d  = UNITY;
            state_d = COMMIT;
          end
        end else if (wd_expired) begin
          rr_d    = gnt_q + 2'd1;
          state_d = IDLE;
        end
      end
      Y_START: state_d = Y_WAIT;
      Y_WAIT: begin
        if (div_done) begin
          ytmp_d  = div_quot;
          state_d = COMMIT;
        end else if (wd_expired) begin
          rr_d    = gnt_q + 2'd1;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        xadd_d[20*gnt_q +: 20] = xtmp_q;
        yadd_d[20*gnt_q +: 20] = ytmp_q;
        upd_d[gnt_q] = 1'b1;
        rr_d    = gnt_q + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A renew arriving in the grant cycle (or in service) re-arms pending.
    pending_d = pending_d | renew;
  end

  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_q      <= '0;
      gnt_q     <= '0;
      xs_q      <= '0;
      ys_q      <= '0;
      num_q     <= '0;
      den_q     <= '0;
      xtmp_q    <= UNITY;
      ytmp_q    <= UNITY;
      xadd_q    <= {4{UNITY}};
      yadd_q    <= {4{UNITY}};
      upd_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      xs_q      <= xs_d;
      ys_q      <= ys_d;
      num_q     <= num_d;
      den_q     <= den_d;
      xtmp_q    <= xtmp_d;
      ytmp_q    <= ytmp_d;
      xadd_q    <= xadd_d;
      yadd_q    <= yadd_d;
      upd_q     <= upd_d;
    end
  end

  assign div_start = (state_q == X_START) || (state_q == Y_START);
  assign div_num   = num_q;
  assign div_den   = den_q;
  assign x_add     = xadd_q;
  assign y_add     = yadd_q;
  assign upd       = upd_q;
  assign busy      = (state_q != IDLE);

endmodule
